// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier controller.
package seq_mul_pkg;

   localparam int SEQ_MUL_WIDTH = 4;
   localparam int CNT_W         = $clog2(SEQ_MUL_WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } seq_mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned WIDTH x WIDTH shift-and-add multiplier driving an external ripple-carry adder.
// Optional SEQ_MUL_ZERO_SKIP_EN: a zero operand bypasses CALC and finishes in one cycle.
module seq_multiplier
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = SEQ_MUL_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic [WIDTH-1:0]     add_a,
   output logic [WIDTH-1:0]     add_b,
   output logic                 add_cin,
   input  logic [WIDTH-1:0]     add_sum,
   input  logic                 add_cout,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           o_dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   seq_mul_state_t       r_state;
   seq_mul_state_t       w_next_state;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [WIDTH-1:0]     r_mcand;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_product;
   logic                 w_accept;
   logic                 w_zero_op;

`ifdef SEQ_MUL_ZERO_SKIP_EN
   assign w_zero_op = (a_in == '0) || (b_in == '0);
`else
   assign w_zero_op = 1'b0;
`endif

   assign w_accept    = (r_state == IDLE) && start;
   // Adder result lands in the upper half while the multiplier bits shift out the bottom.
   assign w_acc_next  = {add_cout, add_sum, r_acc[WIDTH-1:1]};
   assign add_cin     = 1'b0;
   assign product     = r_product;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      add_a        = '0;
      add_b        = '0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = w_zero_op ? DONE : CALC;
            end
         end
         CALC: begin
            busy  = 1'b1;
            add_a = r_acc[2*WIDTH-1:WIDTH];
            add_b = r_acc[0] ? r_mcand : '0;
            if (r_cnt == '0) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         if (w_zero_op) begin
            r_product <= '0;
         end else begin
            r_mcand <= a_in;
            r_acc   <= {{WIDTH{1'b0}}, b_in};
            r_cnt   <= CW'(WIDTH - 1);
         end
      end else if (r_state == CALC) begin
         r_acc <= w_acc_next;
         if (r_cnt == '0) begin
            r_product <= w_acc_next;
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier wired to a 4-bit ripple-carry adder model.
module tb_seq_multiplier;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] a_in;
   logic [3:0] b_in;
   logic [3:0] add_a;
   logic [3:0] add_b;
   logic       add_cin;
   logic [3:0] add_sum;
   logic       add_cout;
   logic       busy;
   logic       done;
   logic [7:0] product;
   logic [1:0] dbg_state;

   logic [7:0] exp_q[$];
   int         n_vec = 0;
   int         n_err = 0;
   bit         saw_cout;
   logic       carry;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .a_in        (a_in),
      .b_in        (b_in),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_cin     (add_cin),
      .add_sum     (add_sum),
      .add_cout    (add_cout),
      .busy        (busy),
      .done        (done),
      .product     (product),
      .o_dbg_state (dbg_state)
   );

   always_comb begin
      add_sum = '0;
      carry   = add_cin;
      for (int i = 0; i < 4; i++) begin
         add_sum[i] = add_a[i] ^ add_b[i] ^ carry;
         carry      = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
      end
      add_cout = carry;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input logic [3:0] a, input logic [3:0] b);
`ifdef SEQ_MUL_ZERO_SKIP_EN
      return (a == 0 || b == 0) ? 1 : 5;
`else
      return 5;
`endif
   endfunction

   task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
      @(negedge clk);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      exp_q.push_back(exp);
   endtask

   // Call right after start is driven; the next rising edge is the accepting one.
   task automatic wait_done(input int lat_exp, input bit collide);
      int         lat = 0;
      int         busy_cyc = 0;
      bit         found = 0;
      logic [7:0] exp_p;
      @(posedge clk);
      for (int cyc = 1; cyc <= 20 && !found; cyc++) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (busy && !done && add_cout) saw_cout = 1'b1;
         if (done) begin
            found = 1'b1;
            lat   = cyc;
            check("cin_zero", add_cin, 0);
         end
         if (collide && (cyc == 2 || cyc == 3)) begin
            start = 1'b1;
            a_in  = 4'd2;
            b_in  = 4'd2;
         end else begin
            start = 1'b0;
            a_in  = 4'($urandom_range(0, 15));
            b_in  = 4'($urandom_range(0, 15));
         end
      end
      exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("done_seen", found, 1);
      check("latency", lat, lat_exp);
      check("busy_cycles", busy_cyc, lat_exp);
      check("product", product, exp_p);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_adder", {add_a, add_b}, 0);
      check("product_hold", product, exp_p);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] ra;
      logic [3:0] rb;
      int         extra_done;

      reset = 1'b1;
      start = 1'b1;
      a_in  = 4'd13;
      b_in  = 4'd11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_product", product, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      check("rst_cin", add_cin, 0);
      check("rst_state", dbg_state, 0);

      // Start stays high across release and must be taken on the first edge.
      reset = 1'b0;
      exp_q.push_back(8'h8F);
      wait_done(5, 1'b0);

      saw_cout = 1'b0;
      launch(4'd15, 4'd15, 8'hE1);
      wait_done(5, 1'b0);
      check("cout_seen", saw_cout, 1);

      launch(4'd0, 4'd9, 8'h00);
      wait_done(exp_lat(4'd0, 4'd9), 1'b0);

      launch(4'd6, 4'd7, 8'h2A);
      wait_done(5, 1'b1);
      extra_done = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) extra_done++;
      end
      check("single_done", extra_done, 0);
      check("busy_after", busy, 0);

      // Reset during the second CALC cycle aborts the 9x9 job.
      @(negedge clk);
      start = 1'b1;
      a_in  = 4'd9;
      b_in  = 4'd9;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      check("mid_busy", busy, 0);
      check("mid_product", product, 0);
      check("mid_done", done, 0);
      check("mid_state", dbg_state, 0);
      @(negedge clk);
      reset = 1'b0;
      extra_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) extra_done++;
      end
      check("mid_no_done", extra_done, 0);

      launch(4'd3, 4'd5, 8'h0F);
      wait_done(5, 1'b0);

      for (int k = 0; k < 6; k++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         if (k == 0) ra = 4'd0;
         launch(ra, rb, 8'(ra) * 8'(rb));
         wait_done(exp_lat(ra, rb), 1'b0);
      end

      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
